// File: rtl/csr_access_unit_pkg.sv
// Shared types and constants for the CSR access unit.
//   csr_op_e     Zicsr funct3 encodings (000 and 100 are reserved).
//   csr_state_e  sequencer states.
//   CSR_XLEN     data width of the CSR file.
//   CSR_RO_PREFIX  addr[11:10] value that marks the read-only CSR space.
package csr_pkg;

   localparam int CSR_XLEN = 32;
   localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

   typedef enum logic [2:0] {
      CSR_OP_RSV0 = 3'b000,
      CSR_OP_RW   = 3'b001,
      CSR_OP_RS   = 3'b010,
      CSR_OP_RC   = 3'b011,
      CSR_OP_RSV4 = 3'b100,
      CSR_OP_RWI  = 3'b101,
      CSR_OP_RSI  = 3'b110,
      CSR_OP_RCI  = 3'b111
   } csr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } csr_state_e;

   // Low two bits select RW/RS/RC; bit 2 selects the immediate form.
   function automatic logic op_is_reserved(input csr_op_e op);
      return (op[1:0] == 2'b00);
   endfunction

   function automatic logic op_is_imm(input csr_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle of all signals between the CSR access unit and its neighbours:
// request channel from issue, response channel back, and the CSR file port.
//   slave  : view of the access unit itself.
//   master : view of the surrounding pipeline / CSR file.
interface csr_access_unit_if;

   logic                          req_valid;
   logic                          req_ready;
   logic [2:0]                    req_funct3;
   logic [11:0]                   req_addr;
   logic [4:0]                    req_rs1_idx;
   logic [csr_pkg::CSR_XLEN-1:0]  req_rs1_data;

   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [csr_pkg::CSR_XLEN-1:0]  rsp_rdata;
   logic                          rsp_illegal;

   logic                          csr_rd;
   logic                          csr_wr;
   logic [11:0]                   rd_addr;
   logic [11:0]                   wr_addr;
   logic [csr_pkg::CSR_XLEN-1:0]  wr_dat;
   logic [csr_pkg::CSR_XLEN-1:0]  rd_dat;

   modport slave (
      input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_illegal,
      input  rsp_ready,
      output csr_rd, csr_wr, rd_addr, wr_addr, wr_dat,
      input  rd_dat
   );

   modport master (
      output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_illegal,
      output rsp_ready,
      input  csr_rd, csr_wr, rd_addr, wr_addr, wr_dat,
      output rd_dat
   );

endinterface

// File: rtl/csr_access_unit_alu.sv
// Combinational read-modify-write datapath for Zicsr operations.
//   op_i   funct3 of the instruction
//   old_i  current CSR value
//   src_i  operand (rs1 value or zero-extended uimm)
//   new_o  value to write back
// Reserved encodings pass old_i through; the caller never writes them.
module csr_alu
   import csr_pkg::*;
(
   input  csr_op_e               op_i,
   input  logic [CSR_XLEN-1:0]   old_i,
   input  logic [CSR_XLEN-1:0]   src_i,
   output logic [CSR_XLEN-1:0]   new_o
);

   always_comb begin
      new_o = old_i;
      case (op_i[1:0])
         2'b01:   new_o = src_i;
         2'b10:   new_o = old_i | src_i;
         2'b11:   new_o = old_i & ~src_i;
         default: new_o = old_i;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// Execute-side sequencer turning a decoded Zicsr instruction into a
// read-modify-write on the CSR file and returning the old value.
//   clk    system clock
//   reset  synchronous, active-low
//   bus    csr_access_unit_if.slave: request, response and CSR file port
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | ready for a request; latches fields on req_valid
// ST_READ  | csr_rd strobe, old value and illegal flag captured
// ST_WRITE | csr_wr strobe when the op writes and is legal
// ST_RESP  | response held until rsp_ready
module csr_access_unit
   import csr_pkg::*;
#(
   parameter bit RO_CHECK = 1'b1,
   parameter int XLEN     = CSR_XLEN
) (
   input  logic                clk,
   input  logic                reset,
   csr_access_unit_if.slave    bus
);

   csr_state_e          state_q,    state_d;
   csr_op_e             funct3_q,   funct3_d;
   logic [11:0]         addr_q,     addr_d;
   logic [4:0]          rs1_idx_q,  rs1_idx_d;
   logic [XLEN-1:0]     rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]     old_q,      old_d;
   logic                illegal_q,  illegal_d;

   logic [XLEN-1:0]     src;
   logic [XLEN-1:0]     new_val;
   logic                do_write;
   logic                illegal_dec;

   assign src = op_is_imm(funct3_q) ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

   // Set/clear with x0 (or uimm 0) is a pure read, so it must not trip
   // the read-only check.
   assign do_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);

   assign illegal_dec = op_is_reserved(funct3_q) ||
                        (RO_CHECK && (addr_q[11:10] == CSR_RO_PREFIX) && do_write);

   csr_alu u_alu (
      .op_i  (funct3_q),
      .old_i (old_q),
      .src_i (src),
      .new_o (new_val)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         funct3_q   <= CSR_OP_RSV0;
         addr_q     <= '0;
         rs1_idx_q  <= '0;
         rs1_data_q <= '0;
         old_q      <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         rs1_idx_q  <= rs1_idx_d;
         rs1_data_q <= rs1_data_d;
         old_q      <= old_d;
         illegal_q  <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      rs1_idx_d  = rs1_idx_q;
      rs1_data_d = rs1_data_q;
      old_d      = old_q;
      illegal_d  = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               funct3_d   = csr_op_e'(bus.req_funct3);
               addr_d     = bus.req_addr;
               rs1_idx_d  = bus.req_rs1_idx;
               rs1_data_d = bus.req_rs1_data;
               state_d    = ST_READ;
            end
         end
         ST_READ: begin
            old_d     = bus.rd_dat;
            illegal_d = illegal_dec;
            state_d   = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are gated by reset so that a reset landing in ST_WRITE
   // suppresses the strobe at the very edge the CSR file would sample it.
   always_comb begin
      bus.req_ready   = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.rsp_rdata   = '0;
      bus.rsp_illegal = 1'b0;
      bus.csr_rd      = 1'b0;
      bus.csr_wr      = 1'b0;
      bus.rd_addr     = '0;
      bus.wr_addr     = '0;
      bus.wr_dat      = '0;
      if (reset) begin
         case (state_q)
            ST_IDLE: begin
               bus.req_ready = 1'b1;
            end
            ST_READ: begin
               bus.csr_rd  = 1'b1;
               bus.rd_addr = addr_q;
            end
            ST_WRITE: begin
               if (do_write && !illegal_q) begin
                  bus.csr_wr  = 1'b1;
                  bus.wr_addr = addr_q;
                  bus.wr_dat  = new_val;
               end
            end
            ST_RESP: begin
               bus.rsp_valid   = 1'b1;
               bus.rsp_illegal = illegal_q;
               bus.rsp_rdata   = illegal_q ? '0 : old_q;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   csr_access_unit_if bus();

   csr_access_unit #(.RO_CHECK(1'b1), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] file_mem [4096];
   logic [31:0] ref_mem  [4096];

   int checks = 0;
   int errors = 0;

   int          wr_cnt, rd_cnt, strobe_err, rsp_seen;
   logic [11:0] wr_addr_seen;
   logic [31:0] wr_dat_seen;
   logic [11:0] cur_addr;

   assign bus.rd_dat = file_mem[bus.rd_addr];

   // CSR file behaviour and strobe observation, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.csr_wr) begin
         wr_cnt = wr_cnt + 1;
         wr_addr_seen = bus.wr_addr;
         wr_dat_seen = bus.wr_dat;
         file_mem[bus.wr_addr] = bus.wr_dat;
      end
      if (bus.csr_rd) begin
         rd_cnt = rd_cnt + 1;
         if (bus.rd_addr != cur_addr) strobe_err = strobe_err + 1;
      end
      if (bus.csr_rd && bus.csr_wr) strobe_err = strobe_err + 1;
      if (!bus.csr_rd && bus.rd_addr != 12'd0) strobe_err = strobe_err + 1;
      if (!bus.csr_wr && (bus.wr_addr != 12'd0 || bus.wr_dat != 32'd0)) strobe_err = strobe_err + 1;
      if (bus.rsp_valid) rsp_seen = rsp_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference: Zicsr semantics straight from the instruction definition.
   function automatic void model(input logic [2:0] f3, input logic [11:0] a,
                                 input logic [4:0] idx, input logic [31:0] d,
                                 input logic [31:0] cur,
                                 output logic ill, output logic wr,
                                 output logic [31:0] nv, output logic [31:0] rdata);
      int kind;
      logic [31:0] src;
      bit writes;
      kind = int'(f3) % 4;
      src = (f3 >= 3'd4) ? 32'(idx) : d;
      writes = (kind == 1) || (idx != 5'd0);
      ill = (kind == 0) || ((a >= 12'hC00) && writes);
      wr = writes && !ill;
      case (kind)
         1: nv = src;
         2: nv = cur | src;
         3: nv = cur & ~src;
         default: nv = cur;
      endcase
      rdata = ill ? 32'd0 : cur;
   endfunction

   // Called at a negedge with the unit idle.
   task automatic txn(input string nm, input logic [2:0] f3, input logic [11:0] a,
                      input logic [4:0] idx, input logic [31:0] d, input int hold);
      logic ill, wr;
      logic [31:0] nv, rdata, held_rdata;
      logic held_ill;
      int lat, unstable;
      model(f3, a, idx, d, ref_mem[a], ill, wr, nv, rdata);
      wr_cnt = 0; rd_cnt = 0; strobe_err = 0; cur_addr = a;
      bus.req_valid = 1'b1;
      bus.req_funct3 = f3;
      bus.req_addr = a;
      bus.req_rs1_idx = idx;
      bus.req_rs1_data = d;
      bus.rsp_ready = (hold == 0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_funct3 = 3'($urandom);
      bus.req_addr = 12'($urandom);
      bus.req_rs1_idx = 5'($urandom);
      bus.req_rs1_data = $urandom;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat = lat + 1;
      end
      check_eq({nm, ".latency"}, 32'(lat), 32'd3);
      check_eq({nm, ".illegal"}, 32'(bus.rsp_illegal), 32'(ill));
      check_eq({nm, ".rdata"}, bus.rsp_rdata, rdata);
      check_eq({nm, ".busy_ready"}, 32'(bus.req_ready), 32'd0);
      held_rdata = bus.rsp_rdata;
      held_ill = bus.rsp_illegal;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_rdata !== held_rdata ||
             bus.rsp_illegal !== held_ill || bus.req_ready !== 1'b0)
            unstable = unstable + 1;
      end
      if (hold > 0) check_eq({nm, ".rsp_stable"}, 32'(unstable), 32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_eq({nm, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
      check_eq({nm, ".idle_rsp"}, 32'(bus.rsp_valid), 32'd0);
      check_eq({nm, ".rd_cnt"}, 32'(rd_cnt), 32'd1);
      check_eq({nm, ".wr_cnt"}, 32'(wr_cnt), 32'(wr));
      if (wr) begin
         check_eq({nm, ".wr_addr"}, 32'(wr_addr_seen), 32'(a));
         check_eq({nm, ".wr_dat"}, wr_dat_seen, nv);
         ref_mem[a] = nv;
      end
      check_eq({nm, ".strobes"}, 32'(strobe_err), 32'd0);
   endtask

   task automatic reset_during_write(input logic [11:0] a, input logic [31:0] d);
      wr_cnt = 0; rd_cnt = 0; strobe_err = 0; rsp_seen = 0; cur_addr = a;
      bus.req_valid = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr = a;
      bus.req_rs1_idx = 5'd4;
      bus.req_rs1_data = d;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_mid.ready_in_reset", 32'(bus.req_ready), 32'd0);
      check_eq("rst_mid.wr_in_reset", 32'(bus.csr_wr), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1 check_eq("rst_mid.ready_release", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      check_eq("rst_mid.ready_next", 32'(bus.req_ready), 32'd1);
      check_eq("rst_mid.wr_cnt", 32'(wr_cnt), 32'd0);
      check_eq("rst_mid.rsp_seen", 32'(rsp_seen), 32'd0);
      check_eq("rst_mid.strobes", 32'(strobe_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [11:0] a;
      logic [4:0]  idx;
      wr_cnt = 0; rd_cnt = 0; strobe_err = 0; rsp_seen = 0; cur_addr = '0;
      wr_addr_seen = '0; wr_dat_seen = '0;
      bus.req_valid = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr = '0;
      bus.req_rs1_idx = '0;
      bus.req_rs1_data = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         v = $urandom;
         file_mem[i] = v;
         ref_mem[i] = v;
      end
      file_mem[12'h340] = 32'h11;        ref_mem[12'h340] = 32'h11;
      file_mem[12'h300] = 32'h8;         ref_mem[12'h300] = 32'h8;
      file_mem[12'hF14] = 32'hABCD0123;  ref_mem[12'hF14] = 32'hABCD0123;

      repeat (3) @(negedge clk);
      check_eq("reset.req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("reset.csr_rd", 32'(bus.csr_rd), 32'd0);
      check_eq("reset.csr_wr", 32'(bus.csr_wr), 32'd0);
      reset = 1'b1;
      #1 check_eq("reset.release_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);

      txn("rw340",   3'b001, 12'h340, 5'd5, 32'hDEADBEEF, 0);
      check_eq("rw340.file", file_mem[12'h340], 32'hDEADBEEF);
      txn("rs300",   3'b010, 12'h300, 5'd3, 32'h80, 0);
      check_eq("rs300.value", ref_mem[12'h300], 32'h88);
      txn("rci300",  3'b111, 12'h300, 5'd8, $urandom, 0);
      check_eq("rci300.value", file_mem[12'h300], 32'h80);
      txn("rsf14x0", 3'b010, 12'hF14, 5'd0, $urandom, 0);
      txn("rwf14",   3'b001, 12'hF14, 5'd7, $urandom, 0);
      txn("f3_100",  3'b100, 12'h305, 5'd9, $urandom, 5);

      reset_during_write(12'h341, 32'h5555AAAA);
      txn("rst_mid.readback", 3'b010, 12'h341, 5'd0, 32'hFFFFFFFF, 0);

      txn("b2b.rw",  3'b001, 12'h341, 5'd2, 32'h100, 0);
      txn("b2b.rs",  3'b010, 12'h341, 5'd1, 32'h1, 0);
      check_eq("b2b.value", file_mem[12'h341], 32'h101);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0: a = 12'h300;
            1: a = 12'h340;
            2: a = 12'h341;
            3: a = 12'hC00;
            4: a = 12'hF14;
            default: a = 12'($urandom);
         endcase
         idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         txn($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), a, idx, $urandom,
             int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Execute-side sequencer that turns a decoded Zicsr instruction into a read-modify-write on the CSR register file.
- Sits between the decode/issue stage and the CSR file.
- Drives the file's csr_rd/csr_wr/rd_addr/wr_addr/wr_dat and consumes its combinational rd_dat.
- Returns the old CSR value plus an illegal-instruction flag over a valid/ready response channel.

Parameters:
- RO_CHECK, 1, when 1, a write to a CSR with addr[11:10]==2'b11 (read-only space) is illegal.
- XLEN, 32, data width; fixed at 32, exposed for package consistency only.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_funct3  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_addr  in  12  CSR address.
- req_rs1_idx  in  5  rs1 index; doubles as uimm for the *I forms.
- req_rs1_data  in  32  rs1 value (ignored for *I forms).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  old CSR value (0 when illegal).
- rsp_illegal  out  1  illegal-instruction flag.
- csr_rd  out  1  read strobe to the CSR file.
- csr_wr  out  1  write strobe to the CSR file.
- rd_addr  out  12  CSR file read address.
- wr_addr  out  12  CSR file write address.
- wr_dat  out  32  CSR file write data.
- rd_dat  in  32  CSR file read data (combinational from rd_addr).

Behaviour:
- Reset (reset==0 at a clk edge): state to IDLE.
  - All outputs 0, except req_ready, which reads 1 once reset is released.
  - Latched request fields cleared.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch funct3, addr, rs1_idx and rs1_data, then go to READ.
- READ (1 cycle):
  - Drive csr_rd=1 and rd_addr=addr_q.
  - Capture rd_dat into old_q at the clock edge.
  - Decode illegal = (funct3 in {000,100}) | (RO_CHECK & addr_q[11:10]==2'b11 & do_write).
  - Go to WRITE.
- Operand: src = funct3[2] ? {27'b0, rs1_idx_q} : rs1_data_q.
- New value: RW → src; RS → old_q | src; RC → old_q & ~src.
- do_write:
  - RW/RWI → always 1.
  - RS/RC/RSI/RCI → 1 only when rs1_idx_q != 0.
  - Consequence: csrrs x, csr, x0 is a pure read and is legal on read-only CSRs.
- WRITE (1 cycle):
  - If do_write & ~illegal: csr_wr=1, wr_addr=addr_q, wr_dat=new value.
  - Otherwise csr_wr=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1, rsp_rdata = illegal ? 0 : old_q, rsp_illegal = illegal.
  - rsp_valid and its data stay stable until rsp_ready.
  - rsp_ready at a clock edge → IDLE.
- Latency: request accept to rsp_valid = 3 cycles. Minimum issue interval is 4 cycles with rsp_ready held high.
- Strobes: csr_rd and csr_wr are one-cycle pulses and never both high in the same cycle. Address and data outputs are 0 whenever their strobe is low.
- Same-address read-after-write ordering is guaranteed by serialisation: the next request's READ cannot occur before the previous WRITE.
- Reset mid-operation (any state):
  - Abandon the request; return to IDLE on the next edge.
  - A pending WRITE is not performed and no response is produced.
- req_valid outside IDLE: ignored (req_ready=0).

Decomposition:
- Shared package csr_pkg:
  - Enum csr_op_e for the funct3 encodings.
  - Constant CSR_RO_PREFIX = 2'b11.
  - FSM state typedef csr_state_e.
- One natural combinational sub-module, csr_alu: inputs op, old, src; output new value. Independently testable.
- FSM, latches and strobes stay in csr_access_unit.

Test Plan:
- CSRRW addr 0x340, rs1_idx=5, rs1_data 0xDEADBEEF, file holding 0x11 → csr_wr pulse with wr_dat 0xDEADBEEF at 0x340; rsp_rdata 0x11; rsp_illegal 0; rsp_valid 3 cycles after accept.
- CSRRS addr 0x300, old 0x0000_0008, rs1_data 0x80 (rs1_idx=3) → wr_dat 0x88, rsp_rdata 0x8. CSRRCI uimm 0x8 on the same CSR → wr_dat 0x80.
- CSRRS addr 0xF14, rs1_idx=0 → no csr_wr, rsp_illegal 0, rsp_rdata equals file content. CSRRW on 0xF14 → no csr_wr, rsp_illegal 1, rsp_rdata 0.
- funct3=100 → rsp_illegal 1, no csr_wr. Hold rsp_ready=0 for 5 cycles → rsp_valid and data stable throughout, req_ready 0; release → IDLE next cycle.
- Assert reset=0 during WRITE of a CSRRW → no csr_wr pulse, no rsp_valid, req_ready=1 the cycle after reset releases.
- Back-to-back: CSRRW 0x341 ← 0x100, then CSRRS 0x341 with 0x1 → second rsp_rdata 0x100, second wr_dat 0x101.
